// File: rtl/config_port_arbiter.sv
// config_port_arbiter: grants one of two requesters the config port, pulses
// ConfigReset at session start, then streams words with a 1-cycle strobe.
module config_port_arbiter #(
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic        req0_active,
    input  logic [31:0] req0_data,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req1_active,
    input  logic [31:0] req1_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        ConfigReset,
    output logic        Owner,
    output logic        Busy,
    output logic        TimeoutErr
);
    typedef enum logic [1:0] {IDLE, START, STREAM} state_t;
    state_t state_q, state_d;
    logic owner_q, owner_d, prev_q, prev_d, terr_q, terr_d;
    logic strobe_q, strobe_d, cfg_q, cfg_d, busy_q, busy_d;
    logic [31:0] data_q, data_d;
    logic [3:0] rst_cnt_q, rst_cnt_d;
    logic [15:0] idle_q, idle_d;
    logic own_active, own_valid, xfer, timeout;
    logic [31:0] own_data;

    assign own_active = owner_q ? req1_active : req0_active;
    assign own_valid  = owner_q ? req1_valid : req0_valid;
    assign own_data   = owner_q ? req1_data : req0_data;
    assign req0_ready = (state_q == STREAM) && !owner_q;
    assign req1_ready = (state_q == STREAM) && owner_q;
    assign xfer       = (state_q == STREAM) && own_valid;
    // Timeout fires on the idle cycle that would bring the count to TIMEOUT_CYCLES
    assign timeout    = !xfer && (({1'b0, idle_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        prev_d    = prev_q;
        terr_d    = terr_q;
        rst_cnt_d = rst_cnt_q;
        idle_d    = idle_q;
        strobe_d  = xfer;
        data_d    = xfer ? own_data : data_q;
        case (state_q)
            IDLE: begin
                if (req0_active || req1_active) begin
                    owner_d   = (req0_active && req1_active) ? !prev_q : req1_active;
                    prev_d    = owner_d;
                    terr_d    = 1'b0;
                    rst_cnt_d = 4'(RESET_CYCLES);
                    idle_d    = 16'd0;
                    state_d   = START;
                end
            end
            START: begin
                if (!own_active) state_d = IDLE;
                else if (rst_cnt_q == 4'd1) state_d = STREAM;
                else rst_cnt_d = rst_cnt_q - 4'd1;
            end
            STREAM: begin
                idle_d = xfer ? 16'd0 : idle_q + 16'd1;
                if (timeout) terr_d = 1'b1;
                if (timeout || !own_active) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cfg_d  = (state_d == START);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            prev_q    <= 1'b1;
            terr_q    <= 1'b0;
            strobe_q  <= 1'b0;
            cfg_q     <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= 32'd0;
            rst_cnt_q <= 4'd0;
            idle_q    <= 16'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            prev_q    <= prev_d;
            terr_q    <= terr_d;
            strobe_q  <= strobe_d;
            cfg_q     <= cfg_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            rst_cnt_q <= rst_cnt_d;
            idle_q    <= idle_d;
        end
    end

    assign WriteData   = data_q;
    assign WriteStrobe = strobe_q;
    assign ConfigReset = cfg_q;
    assign Owner       = owner_q;
    assign Busy        = busy_q;
    assign TimeoutErr  = terr_q;
endmodule

// File: doc/config_port_arbiter.md
CONFIG_PORT_ARBITER -- requirements
Module: config_port_arbiter

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2, meaning cycles ConfigReset is held high at session start (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning idle cycles without a transfer before the session is aborted (range 2..65535).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req0_active  input  1  requester 0 (UART word assembler) claims the config port.
REQ-006 SHALL have port req0_data  input  32  requester 0 word.
REQ-007 SHALL have port req0_valid  input  1  requester 0 word valid.
REQ-008 SHALL have port req0_ready  output  1  requester 0 word accepted this cycle when valid.
REQ-009 SHALL have ports req1_active, req1_data, req1_valid, req1_ready with identical widths and meaning for requester 1 (parallel port).
REQ-010 SHALL have port WriteData  output  32  word to the configuration FSM.
REQ-011 SHALL have port WriteStrobe  output  1  one-cycle write qualifier for WriteData.
REQ-012 SHALL have port ConfigReset  output  1  high pulse whose rising edge resynchronises the configuration FSM.
REQ-013 SHALL have port Owner  output  1  index of granted requester; valid while Busy.
REQ-014 SHALL have port Busy  output  1  high in START and STREAM.
REQ-015 SHALL have port TimeoutErr  output  1  sticky flag: last session ended by timeout.

Function
REQ-016 SHALL implement states IDLE, START, STREAM.
REQ-017 IDLE: if any reqN_active high, SHALL grant next cycle and enter START; both active -> grant the requester that did not own the previous session (requester 0 after reset).
REQ-018 On grant SHALL load Owner, clear TimeoutErr, load a down-counter with RESET_CYCLES.
REQ-019 START: ConfigReset SHALL be 1 for exactly RESET_CYCLES cycles, then state SHALL go to STREAM with ConfigReset 0.
REQ-020 ConfigReset SHALL be 0 in IDLE and STREAM, so each session yields exactly one rising edge.
REQ-021 reqN_ready SHALL be combinationally 1 only when state is STREAM and Owner equals N; the non-owner's ready SHALL be 0 always.
REQ-022 A transfer occurs when the owner's valid and ready are both 1; next cycle WriteStrobe SHALL be 1 and WriteData SHALL equal the transferred word (latency 1, one strobe per transfer, back-to-back every cycle permitted).
REQ-023 WriteStrobe SHALL be 0 in every cycle not following a transfer; WriteData SHALL hold its last value when WriteStrobe is 0.
REQ-024 STREAM: a 16-bit idle counter SHALL clear on each transfer and increment otherwise; on reaching TIMEOUT_CYCLES SHALL set TimeoutErr and go to IDLE.
REQ-025 STREAM: owner's active low SHALL end the session (go to IDLE); a transfer in that same cycle SHALL still complete and strobe.
REQ-026 Non-owner active/valid changes SHALL be ignored during START and STREAM; the non-owner is granted only via IDLE.
REQ-027 Owner's active dropping during START SHALL abort to IDLE after the current cycle, ConfigReset forced 0.
REQ-028 Session end and re-grant SHALL take at least one IDLE cycle (no direct STREAM->START).
REQ-029 Timeout and active-drop in the same cycle SHALL go to IDLE with TimeoutErr set.

Reset
REQ-030 resetn low SHALL immediately force state IDLE, WriteData 0, WriteStrobe 0, ConfigReset 0, Owner 0, Busy 0, TimeoutErr 0, both readies 0, counters 0, previous-owner 1 (so requester 0 wins first tie).
REQ-031 resetn assertion mid-session SHALL drop any in-flight strobe; deassertion SHALL resume in IDLE without spurious ConfigReset or WriteStrobe.

Verification
REQ-032 req0_active=1 alone -> Busy next cycle, ConfigReset high 2 cycles, then req0_ready=1; words 0xFAB0FAB1, 0x00000000 sent back-to-back -> two consecutive WriteStrobe cycles with those values, each one cycle after acceptance.
REQ-033 Both active same cycle after reset -> Owner=0; req1_ready stays 0 throughout; drop req0_active -> IDLE, then Owner=1 with a fresh ConfigReset pulse.
REQ-034 TIMEOUT_CYCLES=8, owner idle in STREAM -> TimeoutErr=1 and Busy=0 after 8 idle cycles; next grant clears TimeoutErr.
REQ-035 Transfer of 0x12345678 in the same cycle req0_active falls -> exactly one WriteStrobe carrying 0x12345678, then IDLE.
REQ-036 resetn pulsed low during STREAM with valid held high -> all outputs 0 asynchronously; after release no WriteStrobe/ConfigReset until a new grant.
